serial_byte_collector: RTL and testbench
========================================

SERIAL_BYTE_COLLECTOR -- requirements
Module: serial_byte_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning bits per assembled word; legal values are 2..16.
REQ-002 The block SHALL have port Clk_In, input, 1, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_In, input, 1: reset Reset_In, asynchronous, active-high.
REQ-004 The block SHALL have port Enable_In, input, 1, collector enable.
REQ-005 The block SHALL have port Bit_Valid_In, input, 1, qualifies Serial_Data_In for one cycle.
REQ-006 The block SHALL have port Serial_Data_In, input, 1, serial bit, MSB first.
REQ-007 The block SHALL have port Frame_Start_In, input, 1, realigns the word boundary.
REQ-008 The block SHALL have port Parallel_Data_Out, output, WIDTH, assembled word.
REQ-009 The block SHALL have port Data_Valid_Out, output, 1, word available.
REQ-010 The block SHALL have port Data_Ready_In, input, 1, consumer accepts the word.
REQ-011 The block SHALL have port Overrun_Out, output, 1, sticky word-lost flag.
REQ-012 The block SHALL have port Overrun_Clear_In, input, 1, clears Overrun_Out.
REQ-013 The block SHALL have port Bit_Count_Out, output, clog2(WIDTH+1), bits collected in the current word.

Function
REQ-014 The collector SHALL run FSM states IDLE (count 0) and COLLECT (count 1..WIDTH-1), independent of an output holding register plus valid flag.
REQ-015 When Enable_In=1 and Bit_Valid_In=1, the block SHALL shift Serial_Data_In into the LSB of the shift register, shifting existing bits toward the MSB, and SHALL increment the count.
REQ-016 The WIDTH-th accepted bit SHALL copy the completed word to the holding register, return the count to 0 and the FSM to IDLE; Data_Valid_Out SHALL be high the cycle after that bit is sampled (latency 1).
REQ-017 Data_Valid_Out and Parallel_Data_Out SHALL stay stable until a cycle with Data_Valid_Out=1 and Data_Ready_In=1; Data_Valid_Out SHALL drop the next cycle unless a new word completes in that same cycle.
REQ-018 Same-cycle accept and completion SHALL load the new word, keep Data_Valid_Out=1, and SHALL NOT set overrun.
REQ-019 Completion while Data_Valid_Out=1 without acceptance SHALL drop the new word, keep the old word, and set Overrun_Out on the next cycle.
REQ-020 Overrun_Clear_In SHALL clear Overrun_Out the next cycle; a same-cycle new overrun SHALL take priority and leave it set.
REQ-021 Frame_Start_In=1 with Enable_In=1 SHALL discard the partial word; if Bit_Valid_In=1 in the same cycle, that bit SHALL be counted as bit 1 of the new word (count becomes 1), otherwise the count SHALL become 0.
REQ-022 Enable_In=0 SHALL ignore Bit_Valid_In and Frame_Start_In, force the count to 0 and the FSM to IDLE, and SHALL leave the holding register, Data_Valid_Out and the output handshake operating.
REQ-023 Bit_Count_Out SHALL equal the registered count and SHALL never reach WIDTH.
REQ-024 Cycles with Bit_Valid_In=0 in COLLECT SHALL hold all state, with no timeout.

Reset
REQ-025 Reset SHALL set the FSM to IDLE, the count to 0, the shift and holding registers to 0, Data_Valid_Out=0, Overrun_Out=0 and Parallel_Data_Out=0.
REQ-026 Reset asserted mid-word or with Data_Valid_Out=1 SHALL discard all data; the first Bit_Valid_In after release SHALL be bit 1.

Structure
REQ-027 FSM state encodings and the default WIDTH constant SHALL reside in the shared shift-register package.
REQ-028 The block SHALL instantiate one sub-module, serial_byte_collector_out_reg, holding the word, the valid flag and the overrun logic; the FSM, counter and shift register SHALL stay in the top level.

Verification
REQ-029 With Data_Ready_In=1, bits 1,0,1,0,0,1,0,1 on 8 consecutive strobes SHALL produce Parallel_Data_Out=0xA5 and one Data_Valid_Out pulse one cycle after the 8th bit.
REQ-030 With Data_Ready_In=0, completing 0x3C then 0xFF SHALL hold 0x3C and set Overrun_Out; a subsequent Overrun_Clear_In pulse SHALL clear Overrun_Out.
REQ-031 With 0x11 pending, a cycle with Data_Ready_In=1 on which the 8th bit of 0x22 arrives SHALL present 0x22, keep Data_Valid_Out=1, and leave Overrun_Out=0.
REQ-032 After 5 bits, Frame_Start_In with Bit_Valid_In=1 and data 1, followed by 7 bits of 0, SHALL produce 0x80.
REQ-033 Enable_In=0 for one cycle after 3 bits SHALL give Bit_Count_Out=0; 8 further bits of 1 SHALL produce 0xFF.
REQ-034 Reset_In asserted after 6 bits with Data_Valid_Out=1 SHALL immediately clear all outputs; 8 bits after release SHALL produce the correct word.

Source files
------------

// File: rtl/serial_byte_collector_pkg.sv
// Shared definitions for the serial byte collector: FSM encoding and default word width.
package serial_byte_collector_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StCollect = 1'b1
    } state_e;

endpackage

// File: rtl/serial_byte_collector_out_reg.sv
// Output holding register with valid/ready handshake and sticky overrun flag.
module serial_byte_collector_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             word_done_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic             ready_i,
    input  logic             overrun_clear_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             can_load;
    logic             word_lost;

    // The slot is free if empty or being drained on this very cycle.
    assign can_load  = !valid_q || ready_i;
    assign word_lost = word_done_i && !can_load;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (word_done_i && can_load) begin
            data_d  = word_i;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (word_lost) begin
            overrun_d = 1'b1;
        end else if (overrun_clear_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_byte_collector.sv
// Assembles MSB-first serial bits into WIDTH-bit words and hands them to a holding register.
module serial_byte_collector
    import serial_byte_collector_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic                       Clk_In,
    input  logic                       Reset_In,
    input  logic                       Enable_In,
    input  logic                       Bit_Valid_In,
    input  logic                       Serial_Data_In,
    input  logic                       Frame_Start_In,
    output logic [WIDTH-1:0]           Parallel_Data_Out,
    output logic                       Data_Valid_Out,
    input  logic                       Data_Ready_In,
    output logic                       Overrun_Out,
    input  logic                       Overrun_Clear_In,
    output logic [$clog2(WIDTH+1)-1:0] Bit_Count_Out
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CntW-1:0]  count_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] word_d;
    logic             last_bit;
    logic             word_done;

    assign word_d    = {shift_q[WIDTH-2:0], Serial_Data_In};
    assign last_bit  = (state_q == StCollect) && (count_q == CntW'(WIDTH - 1));
    assign word_done = Enable_In && !Frame_Start_In && Bit_Valid_In && last_bit;

    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= StIdle;
            count_q <= '0;
            shift_q <= '0;
        end else if (!Enable_In) begin
            state_q <= StIdle;
            count_q <= '0;
        end else if (Frame_Start_In) begin
            // Realign: a coincident strobe becomes bit 1 of the fresh word.
            if (Bit_Valid_In) begin
                shift_q <= {{(WIDTH - 1){1'b0}}, Serial_Data_In};
                count_q <= CntW'(1);
                state_q <= StCollect;
            end else begin
                shift_q <= '0;
                count_q <= '0;
                state_q <= StIdle;
            end
        end else if (Bit_Valid_In) begin
            shift_q <= word_d;
            if (last_bit) begin
                count_q <= '0;
                state_q <= StIdle;
            end else begin
                count_q <= count_q + CntW'(1);
                state_q <= StCollect;
            end
        end
    end

    assign Bit_Count_Out = count_q;

    serial_byte_collector_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk_i          (Clk_In),
        .rst_i          (Reset_In),
        .word_done_i    (word_done),
        .word_i         (word_d),
        .ready_i        (Data_Ready_In),
        .overrun_clear_i(Overrun_Clear_In),
        .data_o         (Parallel_Data_Out),
        .valid_o        (Data_Valid_Out),
        .overrun_o      (Overrun_Out)
    );

endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed self-checking bench for serial_byte_collector (WIDTH = 8).
module tb_serial_byte_collector;

    logic       clk;
    logic       rst;
    logic       en;
    logic       bv;
    logic       sd;
    logic       fs;
    logic [7:0] pdata;
    logic       dvalid;
    logic       rdy;
    logic       ovr;
    logic       ovr_clr;
    logic [3:0] cnt;

    int tests;
    int fails;

    serial_byte_collector #(
        .WIDTH(8)
    ) dut (
        .Clk_In           (clk),
        .Reset_In         (rst),
        .Enable_In        (en),
        .Bit_Valid_In     (bv),
        .Serial_Data_In   (sd),
        .Frame_Start_In   (fs),
        .Parallel_Data_Out(pdata),
        .Data_Valid_Out   (dvalid),
        .Data_Ready_In    (rdy),
        .Overrun_Out      (ovr),
        .Overrun_Clear_In (ovr_clr),
        .Bit_Count_Out    (cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bv = 1'b1;
        sd = b;
        tick();
        bv = 1'b0;
        sd = 1'b0;
    endtask

    task automatic send_range(input logic [7:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        en      = 1'b1;
        bv      = 1'b0;
        sd      = 1'b0;
        fs      = 1'b0;
        rdy     = 1'b1;
        ovr_clr = 1'b0;
        tick();
        tick();
        check("reset_data", pdata, 8'h00);
        check("reset_valid", dvalid, 1'b0);
        check("reset_ovr", ovr, 1'b0);
        check("reset_cnt", cnt, 4'd0);
        rst = 1'b0;
        tick();

        // 0xA5 with consumer ready
        send_range(8'hA5, 7, 1);
        check("a5_cnt7", cnt, 4'd7);
        check("a5_not_yet", dvalid, 1'b0);
        send_bit(1'b1);
        check("a5_valid", dvalid, 1'b1);
        check("a5_data", pdata, 8'hA5);
        check("a5_cnt0", cnt, 4'd0);
        tick();
        check("a5_pulse_drop", dvalid, 1'b0);

        // Overrun: 0x3C held, 0xFF dropped
        rdy = 1'b0;
        send_range(8'h3C, 7, 0);
        check("3c_valid", dvalid, 1'b1);
        check("3c_ovr0", ovr, 1'b0);
        send_range(8'hFF, 7, 0);
        check("ovr_hold_data", pdata, 8'h3C);
        check("ovr_hold_valid", dvalid, 1'b1);
        check("ovr_set", ovr, 1'b1);
        tick();
        check("ovr_sticky", ovr, 1'b1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", ovr, 1'b0);
        check("ovr_data_kept", pdata, 8'h3C);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        check("3c_drained", dvalid, 1'b0);

        // Same-cycle accept and completion
        send_range(8'h11, 7, 0);
        check("11_valid", dvalid, 1'b1);
        send_range(8'h22, 7, 1);
        check("11_held", pdata, 8'h11);
        rdy = 1'b1;
        send_bit(1'b0);
        check("22_data", pdata, 8'h22);
        check("22_valid", dvalid, 1'b1);
        check("22_no_ovr", ovr, 1'b0);
        tick();
        check("22_drop", dvalid, 1'b0);

        // Frame start with coincident bit after 5 bits
        send_range(8'hFF, 7, 3);
        check("fs_cnt5", cnt, 4'd5);
        fs = 1'b1;
        send_bit(1'b1);
        fs = 1'b0;
        check("fs_cnt1", cnt, 4'd1);
        send_range(8'h00, 6, 0);
        check("fs_valid", dvalid, 1'b1);
        check("fs_data", pdata, 8'h80);
        tick();

        // Frame start without a bit restarts at count 0
        send_range(8'hFF, 7, 5);
        fs = 1'b1;
        tick();
        fs = 1'b0;
        check("fs_nobit_cnt0", cnt, 4'd0);

        // Idle strobes hold, enable low clears the count and ignores strobes
        send_range(8'hFF, 7, 5);
        tick();
        tick();
        check("idle_hold_cnt3", cnt, 4'd3);
        en = 1'b0;
        send_bit(1'b1);
        en = 1'b1;
        check("dis_cnt0", cnt, 4'd0);
        check("dis_no_valid", dvalid, 1'b0);
        rdy = 1'b0;
        send_range(8'hFF, 7, 0);
        check("ff_data", pdata, 8'hFF);
        check("ff_valid", dvalid, 1'b1);

        // Asynchronous reset mid-word with a word pending
        send_range(8'h00, 7, 2);
        check("pre_rst_cnt6", cnt, 4'd6);
        rst = 1'b1;
        #1;
        check("rst_async_valid", dvalid, 1'b0);
        check("rst_async_data", pdata, 8'h00);
        check("rst_async_cnt", cnt, 4'd0);
        check("rst_async_ovr", ovr, 1'b0);
        tick();
        rst = 1'b0;
        rdy = 1'b1;
        tick();
        send_range(8'h5A, 7, 1);
        check("post_rst_cnt7", cnt, 4'd7);
        send_bit(1'b0);
        check("post_rst_data", pdata, 8'h5A);
        check("post_rst_valid", dvalid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
